// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter in front of a single-ported data memory.
// Build option: define DMEM_ARB_RR_EN for round-robin on contention (default: CPU fixed priority).
module dmem_arbiter #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [N-1:0]  cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [N-1:0]  dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [N-1:0]  dbg_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          last_owner
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GNT_CPU = 2'd1;
  localparam logic [1:0] GNT_DBG = 2'd2;

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       pick_dbg;
  logic [1:0] gnt_w, we_w;

  always_comb begin
    cpu_gnt   = (state_q == GNT_CPU) && cpu_req;
    dbg_gnt   = (state_q == GNT_DBG) && dbg_req;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_gnt && cpu_we;
        mem_re    = cpu_gnt && !cpu_we;
      end
      GNT_DBG: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_gnt && dbg_we;
        mem_re    = dbg_gnt && !dbg_we;
      end
      default: ;
    endcase
  end

  // Owner including the grant issued this cycle, so contention alternates without a gap.
  always_comb begin
    owner_d = owner_q;
    if (cpu_gnt)
      owner_d = 1'b0;
    else if (dbg_gnt)
      owner_d = 1'b1;
  end

`ifdef DMEM_ARB_RR_EN
  assign pick_dbg = !owner_d;
`else
  assign pick_dbg = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    if (cpu_req && dbg_req)
      state_d = pick_dbg ? GNT_DBG : GNT_CPU;
    else if (cpu_req)
      state_d = GNT_CPU;
    else if (dbg_req)
      state_d = GNT_DBG;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign last_owner = owner_q;
  assign gnt_w      = {dbg_gnt, cpu_gnt};
  assign we_w       = {dbg_we, cpu_we};

  // Per-port read-return registers: index 0 = CPU, 1 = debug.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic         rvalid_q;
    logic [N-1:0] rdata_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt_w[gi] && !we_w[gi];
        if (gnt_w[gi] && !we_w[gi])
          rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = g_port[0].rvalid_q;
  assign cpu_rdata  = g_port[0].rdata_q;
  assign dbg_rvalid = g_port[1].rvalid_q;
  assign dbg_rdata  = g_port[1].rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus queues expected grants/read data,
// a negedge monitor pops and compares whenever the DUT grants or returns read data.
module tb_dmem_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [5:0]  cpu_addr, dbg_addr;
  logic [63:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [63:0] cpu_rdata, dbg_rdata;
  logic        mem_we, mem_re, last_owner;
  logic [5:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.N(64), .AW(6)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .last_owner(last_owner)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed { bit port; bit we; bit [5:0] addr; bit [63:0] wd; } gnt_t;
  typedef struct packed { bit we; bit [5:0] addr; bit [63:0] wd; } acc_t;

  gnt_t        exp_gnt[$];
  logic [63:0] exp_rd_cpu[$], exp_rd_dbg[$];
  acc_t        cpu_acc[$], dbg_acc[$];
  int          gnt_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          pend_cpu = 1'b0, pend_dbg = 1'b0;

  // Memory model: preset contents until a location is written through the DUT.
  bit [63:0] mem_q [64];
  bit        written [64];

  function automatic logic [63:0] preset(input int a);
    if (a == 5)  return 64'hAA;
    if (a == 10) return 64'h55;
    if (a >= 40 && a <= 43) return 64'(1024 + a - 40);
    return 64'h0;
  endfunction

  function automatic logic [63:0] mem_rd(input logic [5:0] a);
    return written[a] ? mem_q[a] : preset(int'(a));
  endfunction

  always_comb mem_rdata = written[mem_addr] ? mem_q[mem_addr] : preset(int'(mem_addr));

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem_q[mem_addr]   <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every grant and every read return against the scoreboard queues.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      pend_cpu <= 1'b0;
      pend_dbg <= 1'b0;
    end else begin
      if (pend_cpu || cpu_rvalid) begin
        if (!pend_cpu) chk("cpu_rvalid_spurious", 64'(cpu_rvalid), 64'd0);
        else begin
          chk("cpu_rvalid", 64'(cpu_rvalid), 64'd1);
          if (exp_rd_cpu.size() > 0) begin
            chk("cpu_rdata", cpu_rdata, exp_rd_cpu[0]);
            exp_rd_cpu.delete(0);
          end
        end
      end
      if (pend_dbg || dbg_rvalid) begin
        if (!pend_dbg) chk("dbg_rvalid_spurious", 64'(dbg_rvalid), 64'd0);
        else begin
          chk("dbg_rvalid", 64'(dbg_rvalid), 64'd1);
          if (exp_rd_dbg.size() > 0) begin
            chk("dbg_rdata", dbg_rdata, exp_rd_dbg[0]);
            exp_rd_dbg.delete(0);
          end
        end
      end
      pend_cpu <= 1'b0;
      pend_dbg <= 1'b0;
      if (cpu_gnt && dbg_gnt) chk("dual_gnt", 64'd1, 64'd0);
      if (cpu_gnt || dbg_gnt) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(dbg_gnt), 64'd2);
        else begin
          chk("gnt_port", 64'(dbg_gnt), 64'(exp_gnt[0].port));
          chk("gnt_mem_we", 64'(mem_we), 64'(exp_gnt[0].we));
          chk("gnt_mem_re", 64'(mem_re), 64'(!exp_gnt[0].we));
          chk("gnt_mem_addr", 64'(mem_addr), 64'(exp_gnt[0].addr));
          if (exp_gnt[0].we) chk("gnt_mem_wdata", mem_wdata, exp_gnt[0].wd);
          else if (exp_gnt[0].port) pend_dbg <= 1'b1;
          else pend_cpu <= 1'b1;
          exp_gnt.delete(0);
          gnt_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic exp_g(input bit port, input bit we, input logic [5:0] a, input logic [63:0] wd);
    exp_gnt.push_back({port, we, a, wd});
  endtask

  task automatic issue(input bit port, input bit we, input logic [5:0] a,
                       input logic [63:0] wd, input logic [63:0] rd);
    if (port) begin
      dbg_acc.push_back({we, a, wd});
      if (!we) exp_rd_dbg.push_back(rd);
    end else begin
      cpu_acc.push_back({we, a, wd});
      if (!we) exp_rd_cpu.push_back(rd);
    end
  endtask

  // Drives both ports: hold each access until its gnt, present the next one the cycle after.
  task automatic run_phase(input int max_cyc);
    int n;
    n = 0;
    gnt_cyc.delete();
    while (cpu_acc.size() > 0 || dbg_acc.size() > 0) begin
      cpu_req = (cpu_acc.size() > 0);
      if (cpu_req) begin
        cpu_we = cpu_acc[0].we; cpu_addr = cpu_acc[0].addr; cpu_wdata = cpu_acc[0].wd;
      end
      dbg_req = (dbg_acc.size() > 0);
      if (dbg_req) begin
        dbg_we = dbg_acc[0].we; dbg_addr = dbg_acc[0].addr; dbg_wdata = dbg_acc[0].wd;
      end
      @(negedge CLOCK_50);
      if (cpu_gnt && cpu_acc.size() > 0) cpu_acc.delete(0);
      if (dbg_gnt && dbg_acc.size() > 0) dbg_acc.delete(0);
      @(posedge CLOCK_50); #1;
      n++;
      if (n > max_cyc) begin
        chk("phase_timeout", 64'(n), 64'(max_cyc));
        cpu_acc.delete();
        dbg_acc.delete();
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("gnt_missing", 64'(exp_gnt.size()), 64'd0);
    chk("cpu_rvalid_missing", 64'(exp_rd_cpu.size()), 64'd0);
    chk("dbg_rvalid_missing", 64'(exp_rd_dbg.size()), 64'd0);
    exp_gnt.delete();
    exp_rd_cpu.delete();
    exp_rd_dbg.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) @(posedge CLOCK_50);
    #3;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_dbg_gnt", 64'(dbg_gnt), 64'd0);
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_dbg_rdata", dbg_rdata, 64'd0);
    chk("rst_last_owner", 64'(last_owner), 64'd1);
    @(negedge CLOCK_50) reset = 1'b1;
    @(posedge CLOCK_50); #1;

    // CPU read of address 5: gnt one cycle after request, rvalid the cycle after.
    start = cyc;
    issue(0, 0, 6'd5, 64'd0, 64'hAA);
    exp_g(0, 0, 6'd5, 64'd0);
    run_phase(10);
    chk("read_gnt_latency", 64'(gnt_cyc.size() > 0 ? gnt_cyc[0] - start : -1), 64'd1);
    chk("idle_mem_addr", 64'(mem_addr), 64'd0);
    chk("idle_mem_wdata", mem_wdata, 64'd0);
    chk("owner_after_cpu", 64'(last_owner), 64'd0);

    // Debug write to the top address, then both ports read it back.
    issue(1, 1, 6'd63, 64'h1234, 64'd0);
    exp_g(1, 1, 6'd63, 64'h1234);
    run_phase(10);
    chk("owner_after_dbg", 64'(last_owner), 64'd1);
    issue(0, 0, 6'd63, 64'd0, 64'h1234);
    issue(1, 0, 6'd63, 64'd0, 64'h1234);
    exp_g(0, 0, 6'd63, 64'd0);
    exp_g(1, 0, 6'd63, 64'd0);
    run_phase(10);

    // Withdrawn CPU request in its grant cycle.
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd5;
    @(posedge CLOCK_50); #1;
    cpu_req = 0;
    #2;
    chk("wd_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("wd_mem_we", 64'(mem_we), 64'd0);
    chk("wd_mem_re", 64'(mem_re), 64'd0);
    chk("wd_last_owner", 64'(last_owner), 64'd1);
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rdata_hold", cpu_rdata, 64'h1234);

    // Contention: 4 CPU writes vs 4 debug reads.
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, 6'(30 + i), 64'(192 + i), 64'd0);
      issue(1, 0, 6'(40 + i), 64'd0, 64'(1024 + i));
    end
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp_g(0, 1, 6'(30 + i), 64'(192 + i));
      exp_g(1, 0, 6'(40 + i), 64'd0);
    end
`else
    for (int i = 0; i < 4; i++) exp_g(0, 1, 6'(30 + i), 64'(192 + i));
    for (int i = 0; i < 4; i++) exp_g(1, 0, 6'(40 + i), 64'd0);
`endif
    run_phase(40);
`ifdef DMEM_ARB_RR_EN
    chk("rr_no_bubble", 64'(gnt_cyc.size() == 8 ? gnt_cyc[7] - gnt_cyc[0] : -1), 64'd7);
`else
    chk("fp_no_bubble", 64'(gnt_cyc.size() == 8 ? gnt_cyc[3] - gnt_cyc[0] : -1), 64'd3);
`endif
    for (int i = 0; i < 4; i++) chk("contention_mem", mem_rd(6'(30 + i)), 64'(192 + i));

    // Reset asserted mid-way through a debug write grant.
    issue(0, 0, 6'd5, 64'd0, 64'hAA);
    exp_g(0, 0, 6'd5, 64'd0);
    run_phase(10);
    chk("owner_pre_abort", 64'(last_owner), 64'd0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 6'd10; dbg_wdata = 64'hDEAD;
    @(posedge CLOCK_50); #2;
    chk("abort_pre_gnt", 64'(dbg_gnt), 64'd1);
    chk("abort_pre_we", 64'(mem_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_dbg_gnt", 64'(dbg_gnt), 64'd0);
    dbg_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd10;
    @(posedge CLOCK_50); #1;
    chk("inrst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("inrst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("inrst_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
    chk("inrst_cpu_rdata", cpu_rdata, 64'd0);
    chk("inrst_dbg_rdata", dbg_rdata, 64'd0);
    chk("inrst_mem_re", 64'(mem_re), 64'd0);
    chk("inrst_last_owner", 64'(last_owner), 64'd1);
    chk("abort_mem_unchanged", mem_rd(6'd10), 64'h55);

    // First arbitration on the first edge after release.
    issue(0, 0, 6'd10, 64'd0, 64'h55);
    exp_g(0, 0, 6'd10, 64'd0);
    @(negedge CLOCK_50) reset = 1'b1;
    start = cyc;
    run_phase(10);
    chk("post_rst_latency", 64'(gnt_cyc.size() > 0 ? gnt_cyc[0] - start : -1), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter N, default 64: data word width.
REQ-002 Parameter AW, default 6: word address width; 64-entry data memory.
REQ-003 CLOCK_50  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU port requests one memory access.
REQ-006 cpu_we  in  1  CPU access type: 1=write, 0=read.
REQ-007 cpu_addr  in  AW  CPU word address.
REQ-008 cpu_wdata  in  N  CPU write data.
REQ-009 cpu_gnt  out  1  one-cycle pulse: CPU access issued to memory this cycle.
REQ-010 cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds read result.
REQ-011 cpu_rdata  out  N  registered CPU read data.
REQ-012 dbg_req, dbg_we, dbg_addr[AW], dbg_wdata[N], dbg_gnt, dbg_rvalid, dbg_rdata[N]: debug/dump port, same directions and meanings as the CPU port.
REQ-013 mem_we  out  1  data memory write enable.
REQ-014 mem_re  out  1  data memory read enable.
REQ-015 mem_addr  out  AW  data memory word address.
REQ-016 mem_wdata  out  N  data memory write data.
REQ-017 mem_rdata  in  N  data memory read data, combinational from mem_addr.
REQ-018 last_owner  out  1  owner of the most recent grant: 0=CPU, 1=debug.

Function
REQ-019 The FSM SHALL have states IDLE, GNT_CPU and GNT_DBG, and a grant is issued only in a GNT_* state.
REQ-020 Arbitration SHALL happen each cycle in IDLE and in the last cycle of a GNT_* state, using current req inputs; the winner's GNT_* state is entered next cycle; no request means IDLE.
REQ-021 In GNT_x, mem_addr/mem_wdata SHALL mux port x inputs, mem_we=x_we, mem_re=!x_we, and x_gnt=1, all combinationally, for exactly one cycle.
REQ-022 If x_req is low in GNT_x (withdrawn), mem_we, mem_re and x_gnt SHALL stay 0 and the access is dropped; the next state follows REQ-020.
REQ-023 On a granted read, x_rdata SHALL capture mem_rdata at the end of the grant cycle, and x_rvalid SHALL pulse the following cycle; a write produces no rvalid.
REQ-024 Latency: req sampled at edge k -> gnt in cycle k+1 -> rvalid in cycle k+2.
REQ-025 Back-to-back: continuous requests SHALL get one grant per cycle with no IDLE bubble.
REQ-026 x_rdata SHALL hold its value until the next granted read on that port.
REQ-027 A requester SHALL hold req, we, addr and wdata stable until gnt; it may reassert in the cycle after gnt for a new access.
REQ-028 When neither or only one port requests, the lone requester SHALL win regardless of priority mode.
REQ-029 mem_* outputs SHALL be 0 when not in a GNT_* state.
REQ-030 last_owner SHALL update on every issued grant (not on withdrawn ones).

Reset
REQ-031 reset low SHALL immediately force state IDLE; all gnt, rvalid, mem_we and mem_re outputs to 0; rdata registers to 0; last_owner to 1.
REQ-032 An access in a GNT_* state when reset asserts SHALL be aborted with no memory write; reads in flight SHALL not produce rvalid after release.
REQ-033 First arbitration SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-034 Macro DMEM_ARB_RR_EN defined: when both ports request, the winner SHALL be the port opposite last_owner (round-robin; after reset the CPU wins first).
REQ-035 Macro DMEM_ARB_RR_EN undefined: when both ports request, the CPU SHALL always win (fixed priority); last_owner is still maintained.

Verification
REQ-036 After reset, raise cpu_req read with cpu_addr=5, mem[5]=0xAA -> cpu_gnt in cycle 1, mem_re=1, mem_addr=5; cpu_rvalid in cycle 2 with cpu_rdata=0xAA.
REQ-037 dbg_req write addr=63, wdata=0x1234 -> dbg_gnt and mem_we for exactly one cycle with mem_addr=63; no dbg_rvalid; a later read of 63 returns 0x1234.
REQ-038 Both ports hold req for 4 accesses: with RR_EN, grants go CPU,DBG,CPU,DBG in consecutive cycles; without it, CPU gets 4 grants first, then DBG.
REQ-039 Drop cpu_req in the GNT_CPU cycle -> no cpu_gnt, mem_we=mem_re=0, last_owner unchanged.
REQ-040 Assert reset mid-cycle in GNT_DBG write -> mem_we falls immediately; memory is unchanged; all outputs are 0 and last_owner=1 after release.
